// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter.
// Includes the FSM encoding, default sizes and port identifiers.
package data_mem_arbiter_pkg;

    localparam int MEM_BYTES_DEF = 16;
    localparam int ADDR_W_DEF    = 32;
    localparam int WORD_W        = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// The caller owns the "last granted" register.
module rr_pick2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT0;
        case (req)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11:   winner = ~last;
            default: winner = PORT0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with one access in flight and range checking before the memory is touched.
//
// state | meaning
// IDLE  | nothing in flight; any request is granted
// ISSUE | memory driven with the latched access (write only if in range)
// RESP  | rvalid to the owner; a new grant may overlap this cycle
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic              rerr,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_readData
);

    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 4);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pick_port;
    logic pick_valid;
    logic grant_ok;
    logic addr_ok;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_port),
        .valid  (pick_valid)
    );

    // Unsigned compare: addresses near the top of the space are rejected, never wrapped.
    assign addr_ok       = (addr_q <= LAST_WORD_ADDR);
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        gnt          = '0;
        rvalid       = '0;
        rerr         = 1'b0;
        rdata        = '0;
        mem_MemWrite = 1'b0;
        grant_ok     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_ok = pick_valid;
            end
            ST_ISSUE: begin
                mem_MemWrite = addr_ok & we_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                rvalid[port_q] = 1'b1;
                rerr           = ~addr_ok;
                if (addr_ok && !we_q) begin
                    rdata = mem_readData;
                end
                grant_ok = pick_valid;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_ok) begin
            gnt[pick_port] = 1'b1;
            last_d         = pick_port;
            port_d         = pick_port;
            we_d           = we[pick_port];
            addr_d         = (pick_port == PORT1) ? addr1 : addr0;
            wdata_d        = (pick_port == PORT1) ? wdata1 : wdata0;
            state_d        = ST_ISSUE;
        end

        // Reset drops the access in flight and silences every strobe this same cycle.
        if (rst) begin
            state_d      = ST_IDLE;
            gnt          = '0;
            rvalid       = '0;
            rerr         = 1'b0;
            rdata        = '0;
            mem_MemWrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= PORT1;
            port_q  <= PORT0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural memory, transaction-timing reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_mem_arbiter;

    localparam int MEM_BYTES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic        rerr;
    logic [31:0] rdata, mem_address, mem_writeData, mem_readData;
    logic        mem_MemWrite;

    int checks = 0;
    int errors = 0;
    int mw_cnt = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .we            (we),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rerr          (rerr),
        .rdata         (rdata),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_readData  (mem_readData)
    );

    // Big-endian byte memory, registered read, preloaded with byte i = i.
    logic [7:0] dmem [MEM_BYTES];
    bit         preloaded = 1'b0;
    always @(posedge clk) begin
        int a;
        a = int'(mem_address[3:0]);
        if (!preloaded) begin
            for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= 8'(i);
            preloaded <= 1'b1;
            mem_readData <= '0;
        end else begin
            if (mem_MemWrite && mem_address <= 32'(MEM_BYTES - 4)) begin
                dmem[a]   <= mem_writeData[31:24];
                dmem[a+1] <= mem_writeData[23:16];
                dmem[a+2] <= mem_writeData[15:8];
                dmem[a+3] <= mem_writeData[7:0];
            end
            if (mem_address <= 32'(MEM_BYTES - 4))
                mem_readData <= {dmem[a], dmem[a+1], dmem[a+2], dmem[a+3]};
            else
                mem_readData <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) if (mem_MemWrite === 1'b1) mw_cnt++;

    // Reference model: a grant at cycle g means the memory access happens in cycle g+1
    // and the response in cycle g+2; the arbiter is busy until the response cycle.
    logic [7:0]  ref_mem [MEM_BYTES];
    bit          ref_init = 1'b0;
    int          cyc = 0;
    int          last_port = 1;
    bit          pend = 1'b0;
    int          p_g, p_port;
    bit          p_we, p_err;
    logic [31:0] p_addr, p_wd, p_rd;
    bit          prev_rst = 1'b0;

    always @(negedge clk) begin : model
        logic [1:0]  e_gnt, e_rv;
        logic        e_rerr, e_mw;
        logic [31:0] e_rd;
        int          w, a;
        if (!ref_init) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i);
            ref_init = 1'b1;
        end
        e_gnt = '0; e_rv = '0; e_rerr = 1'b0; e_mw = 1'b0; e_rd = '0;
        if (prev_rst) begin
            check("addr_after_rst", mem_address, 32'h0);
            check("wdata_after_rst", mem_writeData, 32'h0);
        end
        if (rst) begin
            pend = 1'b0;
            last_port = 1;
        end else begin
            if (pend && cyc == p_g + 1) begin
                p_err = !(p_addr <= 32'(MEM_BYTES - 4));
                e_mw  = !p_err && p_we;
                a     = int'(p_addr[3:0]);
                p_rd  = '0;
                if (!p_err && p_we) begin
                    ref_mem[a]   = p_wd[31:24];
                    ref_mem[a+1] = p_wd[23:16];
                    ref_mem[a+2] = p_wd[15:8];
                    ref_mem[a+3] = p_wd[7:0];
                end else if (!p_err) begin
                    p_rd = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                end
                check("mem_address", mem_address, p_addr);
                check("mem_writeData", mem_writeData, p_wd);
            end
            if (pend && cyc == p_g + 2) begin
                e_rv[p_port] = 1'b1;
                e_rerr = p_err;
                e_rd   = p_rd;
                pend   = 1'b0;
            end
            if (!pend && req != 2'b00) begin
                if (req == 2'b11) w = 1 - last_port;
                else              w = req[1] ? 1 : 0;
                e_gnt[w]  = 1'b1;
                last_port = w;
                pend   = 1'b1;
                p_g    = cyc;
                p_port = w;
                p_we   = we[w];
                p_addr = (w == 1) ? addr1 : addr0;
                p_wd   = (w == 1) ? wdata1 : wdata0;
            end
        end
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("rvalid", 32'(rvalid), 32'(e_rv));
        check("rerr", 32'(rerr), 32'(e_rerr));
        check("rdata", rdata, e_rd);
        check("mem_MemWrite", 32'(mem_MemWrite), 32'(e_mw));
        prev_rst = rst;
        cyc++;
    end

    task automatic wait_gnt(input int p, output bit got);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (gnt[p]) got = 1'b1;
        end
        if (!got) check("gnt_timeout", 32'(got), 32'h1);
    endtask

    task automatic access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit er, output int lat);
        bit got;
        @(posedge clk); #1;
        req[p] = 1'b1;
        we[p]  = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        wait_gnt(p, got);
        @(posedge clk); #1;
        req[p] = 1'b0;
        lat = 1; got = 1'b0; rd = 'x; er = 1'bx;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rvalid[p]) begin got = 1'b1; rd = rdata; er = rerr; end
            else lat++;
        end
        if (!got) check("rvalid_timeout", 32'(got), 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 32'($urandom_range(0, 15));
        else if (r < 9) return 32'($urandom_range(12, 20));
        else            return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        bit          er, got, g1, r1;
        int          lat, mw0, ng;
        int          gport [8];
        int          gk [8];

        rst = 1'b1; req = '0; we = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);

        // 1: port0 read addr 4
        access(0, 1'b0, 32'd4, 32'h0, rd, er, lat);
        check("t1_rdata", rd, 32'h0405_0607);
        check("t1_rerr", 32'(er), 32'h0);
        check("t1_latency", 32'(lat), 32'd2);

        // 2a: port1 write addr 8
        mw0 = mw_cnt;
        access(1, 1'b1, 32'd8, 32'hDEAD_BEEF, rd, er, lat);
        check("t2_write_rdata", rd, 32'h0);
        check("t2_memwrite_cycles", 32'(mw_cnt - mw0), 32'd1);

        // 3: both ports reading addr 0 continuously
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; addr0 = '0; addr1 = '0;
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                if (ng < 8) begin gport[ng] = gnt[1] ? 1 : 0; gk[ng] = k; end
                if (ng > 0) check("t3_gnt_with_rvalid", 32'(rvalid != 2'b00), 32'h1);
                ng++;
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        check("t3_grant_count", 32'(ng), 32'd6);
        for (int i = 0; i < 6 && i < ng; i++) begin
            check("t3_grant_port", 32'(gport[i]), 32'(i % 2));
            check("t3_grant_cycle", 32'(gk[i]), 32'(2 * i));
        end
        repeat (3) @(negedge clk);

        // 2b: port0 reads back the word written by port1
        access(0, 1'b0, 32'd8, 32'h0, rd, er, lat);
        check("t2_readback", rd, 32'hDEAD_BEEF);

        // 4: out-of-range write
        mw0 = mw_cnt;
        access(0, 1'b1, 32'd13, 32'h1122_3344, rd, er, lat);
        check("t4_rerr", 32'(er), 32'h1);
        check("t4_rdata", rd, 32'h0);
        check("t4_memwrite_cycles", 32'(mw_cnt - mw0), 32'd0);
        check("t4_byte13", 32'(dmem[13]), 32'h0D);
        check("t4_byte14", 32'(dmem[14]), 32'h0E);
        check("t4_byte15", 32'(dmem[15]), 32'h0F);

        // 6: port1 requests for one cycle while port0 owns the memory
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr0 = 32'd4;
        wait_gnt(0, got);
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b1; we[1] = 1'b0; addr1 = 32'd0;
        @(negedge clk);
        g1 = gnt[1]; r1 = rvalid[1];
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            g1 |= gnt[1]; r1 |= rvalid[1];
        end
        check("t6_no_gnt1", 32'(g1), 32'h0);
        check("t6_no_rvalid1", 32'(r1), 32'h0);

        // 5: reset during ISSUE of a write to addr 0
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr0 = 32'd0; wdata0 = 32'hFFFF_FFFF;
        wait_gnt(0, got);
        @(posedge clk); #1;
        req[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t5_memwrite_in_rst", 32'(mem_MemWrite), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'h0);
        check("t5_rvalid", 32'(rvalid), 32'h0);
        check("t5_rerr", 32'(rerr), 32'h0);
        check("t5_rdata", rdata, 32'h0);
        check("t5_memwrite", 32'(mem_MemWrite), 32'h0);
        check("t5_mem_address", mem_address, 32'h0);
        check("t5_mem_writeData", mem_writeData, 32'h0);
        @(negedge clk);
        check("t5_no_late_rvalid", 32'(rvalid), 32'h0);
        check("t5_byte0", 32'(dmem[0]), 32'h00);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst    = ($urandom_range(0, 99) < 2);
            req    = 2'($urandom_range(0, 3));
            we     = 2'($urandom_range(0, 3));
            addr0  = rand_addr();
            addr1  = rand_addr();
            wdata0 = $urandom;
            wdata1 = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0; req = '0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < MEM_BYTES; i++) check("final_mem", 32'(dmem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
